// File: rtl/mw_ctrl_pipe.sv
// Control pipeline carrying decoded instruction control from fetch/decode to
// memory/writeback through STAGES registered stages, with stall, flush and load-use bubbles.
module mw_ctrl_pipe #(
  parameter int STAGES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  fetched_instruction,
  input  logic                         instruction_valid,
  input  logic                         reg_write,
  input  logic [1:0]                   writeback_select,
  input  logic                         stall_memory_write,
  input  logic                         flush,
  output logic                         memory_write_enable,
  output logic [1:0]                   writeback_select_memory_write,
  output logic [2:0]                   funct3_memory_write,
  output logic [6:0]                   opcode_memory_write,
  output logic [4:0]                   rd_memory_write,
  output logic                         valid_memory_write,
  output logic                         load_use_stall,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int OccW = $clog2(STAGES + 1);
  localparam logic [1:0] WbLoad = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       regWrite;
    logic [1:0] wbSel;
    logic [2:0] funct3;
    logic [6:0] opcode;
    logic [4:0] rd;
  } stage_t;

  stage_t          stage_q [STAGES];
  stage_t          stage_d [STAGES];
  stage_t          capture;
  logic [OccW-1:0] occupancy_q;
  logic [OccW-1:0] occupancy_d;
  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            useRs1;
  logic            useRs2;
  logic            hazardHit;
  logic            unusedInstrBits;

  assign opcode          = fetched_instruction[6:0];
  assign rs1             = fetched_instruction[19:15];
  assign rs2             = fetched_instruction[24:20];
  assign unusedInstrBits = ^fetched_instruction[31:25];

  // Only opcodes that actually read a source register may create a hazard.
  always_comb begin
    useRs1 = 1'b0;
    useRs2 = 1'b0;
    case (opcode)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        useRs1 = 1'b1;
        useRs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: useRs1 = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    hazardHit = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      if (stage_q[s].valid && stage_q[s].regWrite && stage_q[s].wbSel == WbLoad &&
          stage_q[s].rd != 5'd0 &&
          ((useRs1 && stage_q[s].rd == rs1) || (useRs2 && stage_q[s].rd == rs2))) begin
        hazardHit = 1'b1;
      end
    end
  end

  assign load_use_stall = instruction_valid & hazardHit;

  always_comb begin
    capture.valid    = instruction_valid;
    capture.regWrite = reg_write & instruction_valid;
    capture.wbSel    = writeback_select;
    capture.funct3   = fetched_instruction[14:12];
    capture.opcode   = opcode;
    capture.rd       = fetched_instruction[11:7];
  end

  // Flush beats stall, stall beats bubble insertion; reset is applied in the register.
  always_comb begin
    stage_d     = stage_q;
    occupancy_d = '0;
    if (flush) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_d[s] = '0;
      end
    end else if (!stall_memory_write) begin
      stage_d[0] = load_use_stall ? stage_t'('0) : capture;
      for (int s = 1; s < STAGES; s++) begin
        stage_d[s] = stage_q[s-1];
      end
    end
    for (int s = 0; s < STAGES; s++) begin
      occupancy_d = occupancy_d + OccW'(stage_d[s].valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_q[s] <= '0;
      end
      occupancy_q <= '0;
    end else begin
      stage_q     <= stage_d;
      occupancy_q <= occupancy_d;
    end
  end

  assign memory_write_enable           = stage_q[STAGES-1].regWrite & stage_q[STAGES-1].valid;
  assign writeback_select_memory_write = stage_q[STAGES-1].wbSel;
  assign funct3_memory_write           = stage_q[STAGES-1].funct3;
  assign opcode_memory_write           = stage_q[STAGES-1].opcode;
  assign rd_memory_write               = stage_q[STAGES-1].rd;
  assign valid_memory_write            = stage_q[STAGES-1].valid;
  assign occupancy                     = occupancy_q;

endmodule

// File: tb/tb_mw_ctrl_pipe.sv
// Bench for mw_ctrl_pipe: four instances (STAGES=1..4) share one stimulus stream
// and are compared every cycle against a list-based model of the pipeline.
module tb_mw_ctrl_pipe;

  typedef struct packed {
    logic       valid;
    logic       rw;
    logic [1:0] wb;
    logic [2:0] f3;
    logic [6:0] op;
    logic [4:0] rd;
  } entry_t;

  localparam logic [31:0] ADD_X6_X5_X1 = 32'h00128333;
  localparam logic [31:0] LW_X5        = 32'h0000A283;
  localparam logic [31:0] LW_X0        = 32'h0000A003;
  localparam logic [31:0] ADD_X6_X0_X0 = 32'h00000333;
  localparam logic [31:0] LUI_X5       = 32'h000002B7;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fi;
  logic        iv;
  logic        rwIn;
  logic [1:0]  wbIn;
  logic        stallIn;
  logic        flushIn;

  logic [3:0]      mwe;
  logic [3:0]      vld;
  logic [3:0]      lus;
  logic [3:0][1:0] wbs;
  logic [3:0][2:0] f3o;
  logic [3:0][6:0] opo;
  logic [3:0][4:0] rdo;
  logic [3:0][2:0] occ;

  entry_t mdl [4][4];
  bit     started = 1'b0;
  int     checks  = 0;
  int     passes  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gDut
    localparam int W = $clog2(g + 2);
    logic [W-1:0] occLocal;
    mw_ctrl_pipe #(.STAGES(g + 1)) uDut (
      .clk                           (clk),
      .rst                           (rst),
      .fetched_instruction           (fi),
      .instruction_valid             (iv),
      .reg_write                     (rwIn),
      .writeback_select              (wbIn),
      .stall_memory_write            (stallIn),
      .flush                         (flushIn),
      .memory_write_enable           (mwe[g]),
      .writeback_select_memory_write (wbs[g]),
      .funct3_memory_write           (f3o[g]),
      .opcode_memory_write           (opo[g]),
      .rd_memory_write               (rdo[g]),
      .valid_memory_write            (vld[g]),
      .load_use_stall                (lus[g]),
      .occupancy                     (occLocal)
    );
    assign occ[g] = 3'(occLocal);
  end

  // Hazard rule straight from the register-use table, evaluated over the model list of instance n.
  function automatic bit mdlHazard(int n);
    logic [6:0] op;
    bit useRs1, useRs2, hit;
    op     = fi[6:0];
    useRs2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
    useRs1 = useRs2 || op == 7'h13 || op == 7'h03 || op == 7'h67;
    hit    = 1'b0;
    for (int s = 0; s <= n; s++) begin
      if (mdl[n][s].valid && mdl[n][s].rw && mdl[n][s].wb == 2'b10 && mdl[n][s].rd != 5'd0 &&
          ((useRs1 && mdl[n][s].rd == fi[19:15]) || (useRs2 && mdl[n][s].rd == fi[24:20])))
        hit = 1'b1;
    end
    return hit && (iv == 1'b1);
  endfunction

  function automatic logic [31:0] mkInstr(logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {17'b0, f3, rd, op};
  endfunction

  function automatic logic [31:0] randInstr();
    logic [6:0] op;
    case ($urandom_range(0, 7))
      0: op = 7'h33;
      1: op = 7'h23;
      2: op = 7'h63;
      3: op = 7'h13;
      4: op = 7'h03;
      5: op = 7'h67;
      6: op = 7'h37;
      default: op = 7'h6F;
    endcase
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), op};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic valid, input logic rw,
                               input logic [1:0] wb, input logic stall, input logic fl,
                               input logic rs);
    fi      = instr;
    iv      = valid;
    rwIn    = rw;
    wbIn    = wb;
    stallIn = stall;
    flushIn = fl;
    rst     = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each instance is a list of n+1 entries shifted on every non-held edge.
  always @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      bit     haz;
      entry_t cap;
      haz       = mdlHazard(n);
      cap.valid = iv;
      cap.rw    = rwIn & iv;
      cap.wb    = wbIn;
      cap.f3    = fi[14:12];
      cap.op    = fi[6:0];
      cap.rd    = fi[11:7];
      if (rst || flushIn) begin
        for (int s = 0; s <= n; s++) mdl[n][s] = '0;
      end else if (!stallIn) begin
        for (int s = n; s > 0; s--) mdl[n][s] = mdl[n][s-1];
        mdl[n][0] = haz ? entry_t'('0) : cap;
      end
    end
    started = 1'b1;
  end

  // Every cycle, every instance: last list entry drives the outputs, occupancy is the valid count.
  always @(negedge clk) begin
    if (started) begin
      for (int n = 0; n < 4; n++) begin
        entry_t e;
        int     cnt;
        e   = mdl[n][n];
        cnt = 0;
        for (int s = 0; s <= n; s++) cnt += int'(mdl[n][s].valid);
        checkOutput($sformatf("S%0d valid", n + 1), 32'(vld[n]), 32'(e.valid));
        checkOutput($sformatf("S%0d mwe", n + 1), 32'(mwe[n]), 32'(e.rw & e.valid));
        checkOutput($sformatf("S%0d wbsel", n + 1), 32'(wbs[n]), 32'(e.wb));
        checkOutput($sformatf("S%0d funct3", n + 1), 32'(f3o[n]), 32'(e.f3));
        checkOutput($sformatf("S%0d opcode", n + 1), 32'(opo[n]), 32'(e.op));
        checkOutput($sformatf("S%0d rd", n + 1), 32'(rdo[n]), 32'(e.rd));
        checkOutput($sformatf("S%0d occupancy", n + 1), 32'(occ[n]), 32'(cnt));
        checkOutput($sformatf("S%0d hazard", n + 1), 32'(lus[n]), 32'(mdlHazard(n)));
      end
    end
  end

  initial begin
    for (int n = 0; n < 4; n++)
      for (int s = 0; s < 4; s++) mdl[n][s] = '0;

    // Reset held two cycles with random inputs.
    for (int c = 0; c < 2; c++) begin
      applyStimulus($urandom, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                    1'($urandom), 1'b1);
      tick();
    end
    for (int n = 0; n < 4; n++) begin
      checkOutput($sformatf("reset S%0d valid", n + 1), 32'(vld[n]), 32'd0);
      checkOutput($sformatf("reset S%0d wbsel", n + 1), 32'(wbs[n]), 32'd0);
      checkOutput($sformatf("reset S%0d occupancy", n + 1), 32'(occ[n]), 32'd0);
      checkOutput($sformatf("reset S%0d mwe", n + 1), 32'(mwe[n]), 32'd0);
    end

    // Single-stage passthrough of add x6,x5,x1.
    applyStimulus(ADD_X6_X5_X1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("pass opcode", 32'(opo[0]), 32'h33);
    checkOutput("pass funct3", 32'(f3o[0]), 32'd0);
    checkOutput("pass rd", 32'(rdo[0]), 32'd6);
    checkOutput("pass wbsel", 32'(wbs[0]), 32'd1);
    checkOutput("pass mwe", 32'(mwe[0]), 32'd1);
    checkOutput("pass valid", 32'(vld[0]), 32'd1);

    // Three-stage stall: pipe fills with rd 7,8,9 then freezes for four cycles.
    applyStimulus(32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(mkInstr(3'(k + 1), 5'(7 + k), 7'h13), 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
      tick();
    end
    checkOutput("stall fill rd", 32'(rdo[2]), 32'd7);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(mkInstr(3'd4, 5'd10, 7'h13), 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("stall hold rd", 32'(rdo[2]), 32'd7);
      checkOutput("stall hold occupancy", 32'(occ[2]), 32'd3);
      checkOutput("stall hold funct3", 32'(f3o[2]), 32'd1);
    end
    applyStimulus(mkInstr(3'd4, 5'd10, 7'h13), 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("stall release rd", 32'(rdo[2]), 32'd8);
    checkOutput("two-stage full occupancy", 32'(occ[1]), 32'd2);

    // Flush and stall together on a full two-stage pipe.
    applyStimulus(mkInstr(3'd4, 5'd10, 7'h13), 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("flush+stall valid", 32'(vld[1]), 32'd0);
    checkOutput("flush+stall mwe", 32'(mwe[1]), 32'd0);
    checkOutput("flush+stall occupancy", 32'(occ[1]), 32'd0);

    // Load-use on two stages: lw x5 then add x6,x5,x1.
    applyStimulus(LW_X5, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("lu before load", 32'(lus[1]), 32'd0);
    tick();
    applyStimulus(ADD_X6_X5_X1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("lu load in stage0", 32'(lus[1]), 32'd1);
    tick();
    checkOutput("lu load in stage1", 32'(lus[1]), 32'd1);
    checkOutput("lu load at output rd", 32'(rdo[1]), 32'd5);
    checkOutput("lu bubble occupancy", 32'(occ[1]), 32'd1);
    tick();
    checkOutput("lu released", 32'(lus[1]), 32'd0);
    checkOutput("lu two bubbles", 32'(occ[1]), 32'd0);
    tick();
    checkOutput("lu add in flight", 32'(vld[1]), 32'd0);
    tick();
    checkOutput("lu add valid", 32'(vld[1]), 32'd1);
    checkOutput("lu add rd", 32'(rdo[1]), 32'd6);
    checkOutput("lu add opcode", 32'(opo[1]), 32'h33);

    // Cases that must not raise the hazard, plus one that must.
    applyStimulus(32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(LW_X0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(ADD_X6_X0_X0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("no hazard on x0", 32'(lus[1]), 32'd0);
    applyStimulus(32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(LW_X5, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(LUI_X5, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("no hazard for lui", 32'(lus[1]), 32'd0);
    applyStimulus(ADD_X6_X5_X1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("hazard for add after lw", 32'(lus[1]), 32'd1);
    applyStimulus(32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(mkInstr(3'd0, 5'd5, 7'h13), 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(ADD_X6_X5_X1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("no hazard non-load writer", 32'(lus[1]), 32'd0);
    tick();

    // Randomised traffic with small register numbers so loads and users collide often.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(randInstr(), ($urandom % 10) < 8, 1'($urandom),
                    ($urandom % 2) ? 2'b10 : 2'($urandom), ($urandom % 8) == 0,
                    ($urandom % 20) == 0, ($urandom % 60) == 0);
      tick();
    end
    applyStimulus(32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
